// File: rtl/json_command_parser_if.sv
// Byte-stream input and decoded-command output bundle for json_command_parser.
// master: the side feeding bytes and consuming results; slave: the parser itself.
interface json_command_parser_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        cmd_valid;
  logic [7:0]  t_val;
  logic [15:0] l_speed;
  logic [15:0] r_speed;
  logic [2:0]  command;
  logic        parse_error;
  logic        busy;

  modport master (
    output rx_data,
    output rx_valid,
    input  cmd_valid,
    input  t_val,
    input  l_speed,
    input  r_speed,
    input  command,
    input  parse_error,
    input  busy
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output cmd_valid,
    output t_val,
    output l_speed,
    output r_speed,
    output command,
    output parse_error,
    output busy
  );
endinterface

// File: rtl/json_command_parser.sv
// Parses {"T":<uint>,"L":<sfix>,"R":<sfix>} frames from a UART byte stream into a
// throttle value, two wheel speeds in signed hundredths and a 3-bit drive command.
// Malformed, incomplete or stalled frames are aborted with a one-cycle parse_error.
module json_command_parser #(
  parameter int unsigned MAX_INT_DIGITS = 2,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input logic                  clk,
  input logic                  reset,
  json_command_parser_if.slave bus
);

  localparam logic [7:0] ChLbrace = 8'h7B;
  localparam logic [7:0] ChRbrace = 8'h7D;
  localparam logic [7:0] ChQuote  = 8'h22;
  localparam logic [7:0] ChColon  = 8'h3A;
  localparam logic [7:0] ChComma  = 8'h2C;
  localparam logic [7:0] ChMinus  = 8'h2D;
  localparam logic [7:0] ChDot    = 8'h2E;
  localparam logic [7:0] ChT      = 8'h54;
  localparam logic [7:0] ChL      = 8'h4C;
  localparam logic [7:0] ChR      = 8'h52;

  localparam logic [15:0] SpdP50 = 16'd50;
  localparam logic [15:0] SpdN50 = 16'hFFCE;
  localparam logic [15:0] SpdP25 = 16'd25;
  localparam logic [15:0] SpdN25 = 16'hFFE7;

  typedef enum logic [2:0] {
    StIdle, StKeyOpen, StKey, StKeyClose, StColon, StValue, StDecode
  } state_e;

  typedef enum logic [1:0] {FldT, FldL, FldR} field_e;

  state_e      state_q, state_d;
  field_e      field_q, field_d;
  logic [2:0]  seen_q, seen_d;        // bit0 T, bit1 L, bit2 R
  logic [31:0] acc_q, acc_d;
  logic        neg_q, neg_d;
  logic        dot_q, dot_d;
  logic [3:0]  int_cnt_q, int_cnt_d;
  logic [1:0]  frac_cnt_q, frac_cnt_d;
  logic [7:0]  t_sh_q, t_sh_d;
  logic [15:0] l_sh_q, l_sh_d;
  logic [15:0] r_sh_q, r_sh_d;
  logic [7:0]  t_val_q, t_val_d;
  logic [15:0] l_speed_q, l_speed_d;
  logic [15:0] r_speed_q, r_speed_d;
  logic [2:0]  command_q, command_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        parse_error_q, parse_error_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;

  // Byte classification and value-commit arithmetic, all combinational helpers
  logic        is_ws, is_digit;
  logic [3:0]  digit;
  logic [2:0]  key_bit;
  field_e      key_fld;
  logic [31:0] int_limit;
  logic        int_full;
  logic        has_digits;
  logic [6:0]  scale;
  logic [15:0] mag, value;
  logic        frame_open;
  logic        tmo_hit;

  // Classify the incoming byte and precompute the scaled value of the open field
  always_comb begin
    is_ws    = (bus.rx_data == 8'h20) || (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
    is_digit = (bus.rx_data[7:4] == 4'h3) && (bus.rx_data[3:0] <= 4'd9);
    digit    = bus.rx_data[3:0];
    key_bit  = 3'b000;
    key_fld  = FldT;
    case (bus.rx_data)
      ChT:     begin key_bit = 3'b001; key_fld = FldT; end
      ChL:     begin key_bit = 3'b010; key_fld = FldL; end
      ChR:     begin key_bit = 3'b100; key_fld = FldR; end
      default: begin key_bit = 3'b000; key_fld = FldT; end
    endcase
    int_limit  = (field_q == FldT) ? 32'd3 : MAX_INT_DIGITS;
    int_full   = ({28'd0, int_cnt_q} >= int_limit);
    has_digits = (int_cnt_q != 4'd0) || (frac_cnt_q != 2'd0);
    case (frac_cnt_q)
      2'd0:    scale = 7'd100;
      2'd1:    scale = 7'd10;
      default: scale = 7'd1;
    endcase
    mag        = acc_q[15:0] * {9'd0, scale};
    value      = neg_q ? (16'd0 - mag) : mag;
    frame_open = (state_q != StIdle) && (state_q != StDecode);
    tmo_hit    = (TIMEOUT_CYCLES != 0) && frame_open && !bus.rx_valid &&
                 ((tmo_cnt_q + 32'd1) == TIMEOUT_CYCLES);
  end

  // Next-state, field accumulation, decode and pulse generation
  always_comb begin
    logic err;
    logic restart;
    logic commit;
    state_d       = state_q;
    field_d       = field_q;
    seen_d        = seen_q;
    acc_d         = acc_q;
    neg_d         = neg_q;
    dot_d         = dot_q;
    int_cnt_d     = int_cnt_q;
    frac_cnt_d    = frac_cnt_q;
    t_sh_d        = t_sh_q;
    l_sh_d        = l_sh_q;
    r_sh_d        = r_sh_q;
    t_val_d       = t_val_q;
    l_speed_d     = l_speed_q;
    r_speed_d     = r_speed_q;
    command_d     = command_q;
    cmd_valid_d   = 1'b0;
    parse_error_d = 1'b0;
    err           = 1'b0;
    restart       = 1'b0;
    commit        = 1'b0;
    tmo_cnt_d     = (bus.rx_valid || !frame_open) ? 32'd0 : tmo_cnt_q + 32'd1;

    // Publish the completed frame; a byte arriving now is handled as in IDLE below
    if (state_q == StDecode) begin
      state_d     = StIdle;
      cmd_valid_d = 1'b1;
      t_val_d     = t_sh_q;
      l_speed_d   = l_sh_q;
      r_speed_d   = r_sh_q;
      if (t_sh_q == 8'd0 && l_sh_q == 16'd0 && r_sh_q == 16'd0) begin
        command_d = 3'd0;
      end else if (t_sh_q == 8'd1 && l_sh_q == SpdN50 && r_sh_q == SpdP50) begin
        command_d = 3'd1;
      end else if (t_sh_q == 8'd1 && l_sh_q == SpdN25 && r_sh_q == SpdP25) begin
        command_d = 3'd2;
      end else if (t_sh_q == 8'd1 && l_sh_q == SpdP50 && r_sh_q == SpdP50) begin
        command_d = 3'd3;
      end else if (t_sh_q == 8'd1 && l_sh_q == SpdP25 && r_sh_q == SpdN25) begin
        command_d = 3'd4;
      end else if (t_sh_q == 8'd1 && l_sh_q == SpdP50 && r_sh_q == SpdN50) begin
        command_d = 3'd5;
      end else begin
        command_d = 3'd7;
      end
    end

    if (bus.rx_valid) begin
      if (frame_open && bus.rx_data == ChLbrace) begin
        restart = 1'b1;
      end else begin
        case (state_q)
          StIdle, StDecode: begin
            if (bus.rx_data == ChLbrace) begin
              state_d = StKeyOpen;
              seen_d  = 3'b000;
            end
          end
          StKeyOpen: begin
            if (bus.rx_data == ChQuote) state_d = StKey;
            else if (!is_ws)            err = 1'b1;
          end
          StKey: begin
            if (key_bit == 3'b000 || (seen_q & key_bit) != 3'b000) begin
              err = 1'b1;
            end else begin
              seen_d  = seen_q | key_bit;
              field_d = key_fld;
              state_d = StKeyClose;
            end
          end
          StKeyClose: begin
            if (bus.rx_data == ChQuote) state_d = StColon;
            else                        err = 1'b1;
          end
          StColon: begin
            if (bus.rx_data == ChColon) begin
              state_d    = StValue;
              acc_d      = 32'd0;
              neg_d      = 1'b0;
              dot_d      = 1'b0;
              int_cnt_d  = 4'd0;
              frac_cnt_d = 2'd0;
            end else if (!is_ws) begin
              err = 1'b1;
            end
          end
          StValue: begin
            if (is_digit) begin
              if (dot_q) begin
                if (frac_cnt_q == 2'd2) err = 1'b1;
                else                    frac_cnt_d = frac_cnt_q + 2'd1;
              end else begin
                if (int_full) err = 1'b1;
                else          int_cnt_d = int_cnt_q + 4'd1;
              end
              acc_d = acc_q * 32'd10 + {28'd0, digit};
            end else if (bus.rx_data == ChMinus) begin
              // Sign is legal only before anything else in the value
              if (field_q == FldT || neg_q || dot_q || has_digits) err = 1'b1;
              else                                                 neg_d = 1'b1;
            end else if (bus.rx_data == ChDot) begin
              if (field_q == FldT || dot_q) err = 1'b1;
              else                          dot_d = 1'b1;
            end else if (bus.rx_data == ChComma) begin
              commit  = 1'b1;
              state_d = StKeyOpen;
            end else if (bus.rx_data == ChRbrace) begin
              commit  = 1'b1;
              state_d = StDecode;
              if (seen_q != 3'b111) err = 1'b1;
            end else begin
              err = 1'b1;
            end
          end
          default: err = 1'b1;
        endcase
      end
    end else if (tmo_hit) begin
      err = 1'b1;
    end

    // Land the finished value in its shadow; outputs only change in DECODE
    if (commit) begin
      if (!has_digits) err = 1'b1;
      case (field_q)
        FldT: begin
          if (acc_q > 32'd255) err = 1'b1;
          t_sh_d = acc_q[7:0];
        end
        FldL:    l_sh_d = value;
        default: r_sh_d = value;
      endcase
    end

    if (restart) begin
      parse_error_d = 1'b1;
      state_d       = StKeyOpen;
      seen_d        = 3'b000;
      tmo_cnt_d     = 32'd0;
    end else if (err) begin
      parse_error_d = 1'b1;
      state_d       = StIdle;
      tmo_cnt_d     = 32'd0;
    end
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      field_q       <= FldT;
      seen_q        <= 3'b000;
      acc_q         <= 32'd0;
      neg_q         <= 1'b0;
      dot_q         <= 1'b0;
      int_cnt_q     <= 4'd0;
      frac_cnt_q    <= 2'd0;
      t_sh_q        <= 8'd0;
      l_sh_q        <= 16'd0;
      r_sh_q        <= 16'd0;
      t_val_q       <= 8'd0;
      l_speed_q     <= 16'd0;
      r_speed_q     <= 16'd0;
      command_q     <= 3'd0;
      cmd_valid_q   <= 1'b0;
      parse_error_q <= 1'b0;
      tmo_cnt_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      field_q       <= field_d;
      seen_q        <= seen_d;
      acc_q         <= acc_d;
      neg_q         <= neg_d;
      dot_q         <= dot_d;
      int_cnt_q     <= int_cnt_d;
      frac_cnt_q    <= frac_cnt_d;
      t_sh_q        <= t_sh_d;
      l_sh_q        <= l_sh_d;
      r_sh_q        <= r_sh_d;
      t_val_q       <= t_val_d;
      l_speed_q     <= l_speed_d;
      r_speed_q     <= r_speed_d;
      command_q     <= command_d;
      cmd_valid_q   <= cmd_valid_d;
      parse_error_q <= parse_error_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.parse_error = parse_error_q;
  assign bus.t_val       = t_val_q;
  assign bus.l_speed     = l_speed_q;
  assign bus.r_speed     = r_speed_q;
  assign bus.command     = command_q;
  assign bus.busy        = (state_q != StIdle);

endmodule
